out_packing: RTL
================

# out_packing

Result-side counterpart of the operand unpacker. It takes the raw sign, exponent sum and 16-bit mantissa product from the multiplier core and produces a packed BFloat16 word: sign `[15]`, exponent `[14:7]`, mantissa `[6:0]`. Along the way it normalises, rounds to nearest-even, and saturates on overflow or flushes on underflow. It is a two-stage pipeline with valid/ready handshakes on both sides and sits between the mantissa multiplier and the block output.

## Interface
Parameters:
- `BIAS`, default 127: exponent bias subtracted from the exponent sum.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents an operand set.
- `in_ready`  out  1  block accepts the operand set this cycle.
- `s_in`  in  1  result sign (Sa ^ Sb).
- `exp_sum`  in  9  unsigned expa + expb, range 0..510.
- `prod`  in  16  manta * mantb, each with hidden bit set; range 0x4000..0xFE01.
- `zero_in`  in  1  force a signed-zero result (an operand was zero).
- `out_valid`  out  1  packed result available.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `result`  out  16  packed BFloat16 result.
- `ovf`  out  1  result saturated to infinity.
- `unf`  out  1  result flushed to zero by underflow (not asserted for `zero_in`).

## Operation
- **Normalise.**
  - If `prod[15]`=1: m=`prod[14:8]`, g=`prod[7]`, st=|`prod[6:0]`, e=`exp_sum`-`BIAS`+1.
  - Else: m=`prod[13:7]`, g=`prod[6]`, st=|`prod[5:0]`, e=`exp_sum`-`BIAS`.
  - e is computed as 11-bit signed.
- **Round (RNE).** Increment if g & (st | m[0]). If m=0x7F and it increments, m becomes 0x00 and e increases by 1.
- **Pack, in priority order:**
  - `zero_in` → {s,15'h0}, flags 0.
  - e≥255 → {s,8'hFF,7'h0}, `ovf`=1.
  - e≤0 → {s,15'h0}, `unf`=1.
  - Otherwise → {s,e[7:0],m}.
- Subnormals are not produced. NaN inputs are not handled.
- **Stage 1** registers s, `zero_in`, m, e, and the round-increment decision. **Stage 2** registers `result`, `ovf` and `unf`.
- **Handshake:**
  - ld2 = !`out_valid` | `out_ready`.
  - ld1 = !s1_valid | ld2.
  - `in_ready` = ld1.
  - A transfer occurs on `in_valid`&`in_ready` or `out_valid`&`out_ready`.
- **Stall.** While `out_valid`&!`out_ready`, stage 2 holds `result`/`ovf`/`unf` stable. Stage 1 holds if it is occupied.
- No input is lost or duplicated.

## Timing
- **Reset.** `out_valid`=0, `result`=16'h0000, `ovf`=0, `unf`=0, s1_valid=0. `in_ready` is 1 during and right after reset.
- **Reset mid-operation** discards both stages immediately, asynchronously.
- **Latency.** An input accepted at edge N appears with `out_valid`=1 after edge N+1 when unstalled. That is 2 register stages.
- **Throughput.** One result per cycle while `out_ready`=1.
- **Full pipeline.** With both stages full and `out_ready`=0, `in_ready`=0. `in_ready` is combinational from `out_ready`.
- **Simultaneous events.** When the output is consumed and a new input accepted in the same cycle, both stages advance with no bubble.
- Outputs are held stable whenever `out_valid`=1 and `out_ready`=0.

## Test plan
- **1.0×1.0 and 1.5×1.5.**
  - `exp_sum`=254, `prod`=0x4000 → `result`=0x3F80 two cycles after acceptance.
  - `prod`=0x9000, s=1 → 0xC010.
- **Round-to-nearest-even.**
  - `exp_sum`=254, `prod`=0x4040 (tie, even) → 0x3F80.
  - `prod`=0x40C0 (tie, odd) → 0x3F82.
  - `prod`=0x4041 → 0x3F81.
- **Rounding carry.** `exp_sum`=254, `prod`=0x7FFF → 0x4000, `ovf`=0.
- **Extremes.**
  - `exp_sum`=400, s=0 → 0x7F80, `ovf`=1.
  - `exp_sum`=100, s=1 → 0x8000, `unf`=1.
  - `zero_in`=1, s=1 → 0x8000, `unf`=0.
- **Backpressure.** Stream 4 inputs with `in_valid` held high and `out_ready`=0 for 4 cycles → `in_ready` drops after 2 accepted. Raising `out_ready` then delivers all 4 results in order with no loss or duplication.
- **Reset.** Assert `rst_n`=0 with both stages full → `out_valid`, `result`, `ovf`, `unf` = 0 immediately. The first post-reset input returns correctly with latency 2.

Source files
------------

// File: rtl/out_packing.sv
// BFloat16 result packer: normalise, round-to-nearest-even, saturate/flush, pack.
// Two register stages with valid/ready on both sides; a stalled output freezes stage 2 and an occupied stage 1.
module out_packing #(
   parameter int BIAS = 127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        s_in,
   input  logic [8:0]  exp_sum,
   input  logic [15:0] prod,
   input  logic        zero_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        ovf,
   output logic        unf
);

   localparam logic [10:0] L_BIAS = 11'(BIAS);

   logic        w_ld1;
   logic        w_ld2;
   logic        w_hi;
   logic [6:0]  w_m;
   logic        w_g;
   logic        w_st;
   logic [10:0] w_e;
   logic        w_inc;

   logic        r_s1_vld;
   logic        r_s;
   logic        r_zero;
   logic [6:0]  r_m;
   logic [10:0] r_e;
   logic        r_inc;

   logic        r_out_vld;
   logic [15:0] r_result;
   logic        r_ovf;
   logic        r_unf;

   logic [7:0]         w_mr;
   logic signed [10:0] w_e2;
   logic [15:0]        w_res;
   logic               w_ovf;
   logic               w_unf;

   assign w_ld2    = !r_out_vld | out_ready;
   assign w_ld1    = !r_s1_vld | w_ld2;
   assign in_ready = w_ld1;

   // Product lies in [1,4): bit 15 set means one extra position of exponent.
   assign w_hi  = prod[15];
   assign w_m   = w_hi ? prod[14:8] : prod[13:7];
   assign w_g   = w_hi ? prod[7]    : prod[6];
   assign w_st  = w_hi ? |prod[6:0] : |prod[5:0];
   assign w_e   = {2'b00, exp_sum} - L_BIAS + {10'd0, w_hi};
   assign w_inc = w_g & (w_st | w_m[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s      <= 1'b0;
         r_zero   <= 1'b0;
         r_m      <= 7'd0;
         r_e      <= 11'd0;
         r_inc    <= 1'b0;
      end else if (w_ld1) begin
         r_s1_vld <= in_valid;
         if (in_valid) begin
            r_s    <= s_in;
            r_zero <= zero_in;
            r_m    <= w_m;
            r_e    <= w_e;
            r_inc  <= w_inc;
         end
      end
   end

   // A mantissa carry-out leaves the 7 fraction bits at zero and bumps the exponent.
   assign w_mr = {1'b0, r_m} + {7'd0, r_inc};
   assign w_e2 = $signed(r_e + {10'd0, w_mr[7]});

   always_comb begin
      w_res = {r_s, r_e[7:0] + {7'd0, w_mr[7]}, w_mr[6:0]};
      w_ovf = 1'b0;
      w_unf = 1'b0;
      if (r_zero) begin
         w_res = {r_s, 15'h0000};
      end else if (w_e2 >= 11'sd255) begin
         w_res = {r_s, 8'hFF, 7'h00};
         w_ovf = 1'b1;
      end else if (w_e2 <= 11'sd0) begin
         w_res = {r_s, 15'h0000};
         w_unf = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_result  <= 16'h0000;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else if (w_ld2) begin
         r_out_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_result <= w_res;
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
         end
      end
   end

   assign out_valid = r_out_vld;
   assign result    = r_result;
   assign ovf       = r_ovf;
   assign unf       = r_unf;

endmodule
